// File: rtl/arm_fetch_pkg.sv
// Shared fetch-side definitions for the instruction-memory responder.
//   INST_NOP     : instruction returned for out-of-range fetches
//   LATENCY_MIN/MAX : legal accept-to-response latency range
//   resp_t       : packed response record {inst, addr, err}
//   out_max()    : credit limit (outstanding requests) for a given latency
package arm_fetch_pkg;

    localparam logic [31:0] INST_NOP    = 32'hE1A00000;
    localparam int          LATENCY_MIN = 1;
    localparam int          LATENCY_MAX = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } resp_t;

    // One credit per pipeline stage plus one for the response being held at
    // the FIFO head, so the FIFO can never be asked to take more than it holds.
    function automatic int out_max(input int latency);
        return latency + 1;
    endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Show-ahead synchronous FIFO holding responses until the fetch stage takes them.
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset (empties the FIFO)
//   clear      : synchronous clear (flush), same effect as reset
//   push       : write push_data this cycle (ignored when full)
//   push_data  : entry to store
//   pop        : consume the head this cycle (ignored when empty)
//   empty      : no entry stored
//   head       : oldest entry, valid whenever empty=0
module imem_resp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    used;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (used != CW'(DEPTH));
    assign do_pop  = pop && (used != '0);
    assign empty   = (used == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            used <= used + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage.
// Holds a loadable store of DEPTH words and returns each fetched word LATENCY
// cycles after acceptance, in request order, through a credit-limited
// response FIFO so a frozen fetch stage loses nothing.
//   clk, rst                 : clock, synchronous active-low reset
//   req_valid/req_addr       : word-address fetch request
//   req_ready                : request accepted when valid && ready at posedge
//   resp_valid/resp_ready    : response handshake (resp_ready=0 freezes)
//   resp_inst/addr/err       : fetched word, echoed address, out-of-range flag
//   flush                    : drop every outstanding response
//   ld_en/ld_addr/ld_data    : store load port (works during reset too)
module imem_responder
    import arm_fetch_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2     // legal range LATENCY_MIN..LATENCY_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic [31:0] resp_addr,
    output logic        resp_err,
    input  logic        resp_ready,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int OUT_MAX = out_max(LATENCY);
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW      = $clog2(OUT_MAX + 1);

    logic [31:0]        store [DEPTH];
    logic [CW-1:0]      count;
    logic               accept;
    logic               deliver;
    logic               req_in_range;
    logic               ld_in_range;
    logic [LATENCY-1:0] pipe_valid;
    resp_t              pipe_data [LATENCY];
    resp_t              req_entry;
    resp_t              head;
    logic               fifo_empty;
    logic               fifo_push;

    assign req_ready    = rst && (count < CW'(OUT_MAX));
    assign accept       = req_valid && req_ready;
    assign resp_valid   = !fifo_empty;
    assign deliver      = resp_valid && resp_ready;
    assign req_in_range = (req_addr < 32'(DEPTH));
    assign ld_in_range  = (ld_addr < 32'(DEPTH));

    // Store read happens at accept; a same-cycle load lands on the same edge,
    // so the request sees the old word.
    always_comb begin
        req_entry.addr = req_addr;
        req_entry.err  = !req_in_range;
        req_entry.inst = req_in_range ? store[req_addr[AW-1:0]] : INST_NOP;
    end

    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) store[ld_addr[AW-1:0]] <= ld_data;
    end

    // Outstanding credits: everything accepted and not yet handed over.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= CW'(accept);
        end else begin
            count <= count + CW'(accept) - CW'(deliver);
        end
    end

    // Fixed-latency pipeline; it never stalls because credits guarantee room
    // in the FIFO. Stage 0 takes a flush-cycle request as a post-flush entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= flush ? 1'b0 : pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_data[0] <= req_entry;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    assign fifo_push = pipe_valid[LATENCY-1] && !flush;

    imem_resp_fifo #(
        .DEPTH (OUT_MAX),
        .WIDTH ($bits(resp_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (pipe_data[LATENCY-1]),
        .pop       (deliver),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Idle outputs read as zero rather than a stale head entry.
    assign resp_inst = resp_valid ? head.inst : '0;
    assign resp_addr = resp_valid ? head.addr : '0;
    assign resp_err  = resp_valid && head.err;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch stage's word-addressed PC requests over a valid/ready request/response handshake. It holds a loadable instruction store of DEPTH 32-bit words and returns each instruction after a fixed pipelined latency. Responses are buffered so a frozen fetch stage applies backpressure without losing data. A flush drops every in-flight response so a branch redirect never sees stale instructions. It sits between the fetch stage and the instruction store, replacing the hard-wired instruction table.

## Interface
- DEPTH, 64, instruction words held; addresses 0..DEPTH-1 valid
- LATENCY, 2, accept-to-response cycles; legal range 1..4
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  fetch presents an address
- req_addr  in  32  word address (PC in words, not bytes)
- req_ready  out  1  request accepted when req_valid && req_ready at posedge
- resp_valid  out  1  response available
- resp_inst  out  32  instruction word
- resp_addr  out  32  echo of the request address
- resp_err  out  1  address was >= DEPTH
- resp_ready  in  1  fetch consumes; low = freeze
- flush  in  1  discard all outstanding responses (branch taken)
- ld_en  in  1  write enable for store loading
- ld_addr  in  32  load word address
- ld_data  in  32  load data

## Operation
- Reset (rst=0 at posedge):
  - outstanding count := 0
  - pipeline valid bits := 0
  - response FIFO emptied
  - resp_valid=0, resp_inst=0, resp_addr=0, resp_err=0
  - req_ready=0 while rst=0
  - Store contents are not reset.
- Outstanding count: accepted requests not yet handed over. OUT_MAX = LATENCY+1.
- req_ready = rst && (count < OUT_MAX). It does not depend on resp_ready.
- Count update per cycle: +1 on request accept, -1 on resp_valid && resp_ready. Both may happen in the same cycle.
- Read path:
  - The address is registered at accept and moves through a LATENCY-deep valid/address/data pipeline.
  - The store read happens at accept.
  - On exit, the entry is pushed into a response FIFO of depth OUT_MAX.
  - The FIFO head drives resp_*.
  - Because of the credit limit, the FIFO never overflows.
- Out-of-range address (req_addr >= DEPTH): the request still occupies a credit. Response is resp_inst=32'hE1A00000 (NOP), resp_err=1.
- Ordering: responses are returned strictly in request order.
- Flush (flush=1 at posedge):
  - All pipeline valid bits and FIFO entries are cleared.
  - A handshake in the same cycle still counts as delivered.
  - count := (request accepted this cycle) ? 1 : 0.
  - A request accepted in the flush cycle is post-flush and is returned normally.
  - resp_valid=0 in the cycle after flush unless LATENCY's path refills it.
- Load:
  - ld_en=1 writes ld_data to ld_addr at posedge.
  - Writes with ld_addr >= DEPTH are ignored.
  - A request to the same address accepted in the same cycle reads the old data.
  - Loading is legal at any time, including during reset.

## Timing
- Request accepted at edge E with pipeline and FIFO empty: resp_valid=1 after edge E+LATENCY.
  - LATENCY=1 means the response is visible in the cycle following acceptance.
- With resp_ready held at 1: one response per cycle, no bubbles.
- With resp_ready=0: at most OUT_MAX requests are accepted, then req_ready=0.
  - On release, req_ready returns to 1 one cycle after the first handshake, because count is registered.
- resp_* hold stable while resp_valid=1 and resp_ready=0.
- Reset overrides flush, load-read, and handshakes in the same cycle.
- Reset mid-operation drops everything. No stale response appears after rst returns to 1.

## Structure
- Shared package arm_fetch_pkg:
  - NOP constant 32'hE1A00000
  - LATENCY min/max constants
  - a packed response struct {inst, addr, err}
- One sub-module, imem_resp_fifo: show-ahead synchronous FIFO, parameterised depth, with a clear input used by flush and reset.
- The store array and the latency pipeline live in the top module.

## Test plan
- Back-to-back fetch:
  - Stimulus: load words 0..3 = E3A00014, E3A01A01, E3A02103, E0823002; LATENCY=2, resp_ready=1; requests 0..3 on consecutive cycles.
  - Required response: responses in order, first after edge E+2, four consecutive cycles, resp_err=0.
- Backpressure:
  - Stimulus: resp_ready=0; request addresses 0,1,2,3.
  - Required response: req_ready falls after 3 accepts and address 3 is held. After resp_ready=1, responses come out as 0,1,2,3 with data intact.
- Flush:
  - Stimulus: requests 4 and 5 outstanding; flush=1 together with req_addr=10 accepted.
  - Required response: only the addr-10 response appears, 2 cycles later; 4 and 5 are never presented.
- Out of range:
  - Stimulus: DEPTH=64, request addr 64.
  - Required response: resp_inst=E1A00000, resp_err=1, resp_addr=64.
- Reset mid-operation:
  - Stimulus: rst=0 for one cycle with 2 outstanding.
  - Required response: resp_valid=0 and req_ready=0 during reset; no responses afterwards until a new request is made.
- Load/read collision:
  - Stimulus: ld_en writes addr 7 := 0xDEADBEEF in the same cycle that addr 7 is requested.
  - Required response: the old word is returned; the next request to addr 7 returns 0xDEADBEEF.
